// File: rtl/pixel_write_arbiter.sv
// Collects finished pixels from NCH compute channels with round-robin arbitration,
// buffers them in a small FIFO and drains them through an Avalon-style write master.
module pixel_write_arbiter #(
    parameter int NCH   = 4,
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic [NCH-1:0]             done,
    input  logic [NCH*AW-1:0]          cataddresses,
    input  logic [NCH*DW-1:0]          catpixels,
    input  logic [AW-1:0]              base_addr,
    input  logic                       wait_request,
    output logic [NCH-1:0]             free,
    output logic [AW-1:0]              write_address,
    output logic [DW-1:0]              write_data,
    output logic                       write_enable,
    output logic [$clog2(DEPTH):0]     fifo_level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int RW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [AW-1:0]  addr_mem_q [DEPTH];
    logic [DW-1:0]  data_mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q, level_d;
    logic [RW-1:0]  rr_q, rr_d;
    logic [NCH-1:0] block_q, block_d;
    logic [NCH-1:0] free_q, free_d;

    logic           full;
    logic           pop;
    logic           push;
    logic           grant_valid;
    logic [RW-1:0]  grant_idx;
    logic [NCH-1:0] eligible;
    logic [AW-1:0]  push_addr;
    logic [DW-1:0]  push_data;
    logic [PW-1:0]  head_ptr;

    // Handshake: write_enable is "valid", !wait_request is "ready"; an entry
    // leaves the FIFO on every edge where both are high, otherwise it is held.
    assign full     = (level_q == LW'(DEPTH));
    assign pop      = (level_q != '0) && !wait_request;
    assign eligible = done & ~block_q;

    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int off = 0; off < NCH; off++) begin
            idx = int'(rr_q) + off;
            if (idx >= NCH) idx = idx - NCH;
            if (!grant_valid && eligible[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = RW'(idx);
            end
        end
    end

    assign push      = grant_valid && (!full || pop);
    assign push_addr = base_addr + cataddresses[int'(grant_idx)*AW +: AW];
    assign push_data = catpixels[int'(grant_idx)*DW +: DW];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        rr_d     = rr_q;
        free_d   = '0;
        // A held done stays blocked until the channel lowers it for one edge.
        block_d  = block_q & done;
        if (push) begin
            wr_ptr_d            = wr_ptr_q + PW'(1);
            rr_d                = (grant_idx == RW'(NCH - 1)) ? '0 : grant_idx + RW'(1);
            free_d[grant_idx]   = 1'b1;
            block_d[grant_idx]  = 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        level_d = level_q + LW'(push) - LW'(pop);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rr_q     <= '0;
            block_q  <= '0;
            free_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_q[i] <= '0;
                data_mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            rr_q     <= rr_d;
            block_q  <= block_d;
            free_q   <= free_d;
            if (push) begin
                addr_mem_q[wr_ptr_q] <= push_addr;
                data_mem_q[wr_ptr_q] <= push_data;
            end
        end
    end

    // When empty, present the slot just popped so address/data hold their last values.
    assign head_ptr      = (level_q != '0) ? rd_ptr_q : rd_ptr_q - PW'(1);
    assign write_address = addr_mem_q[head_ptr];
    assign write_data    = data_mem_q[head_ptr];
    assign write_enable  = (level_q != '0);
    assign fifo_level    = level_q;
    assign free          = free_q;

endmodule
